// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the calculator display path.
// State enum, 7-seg glyphs (active-low {dp,g..a}), display limit.
package calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [13:0] MAX_DISP = 14'd9999;

endpackage

// File: rtl/bcd_display_if.sv
// Load/status/display bundle between arithmetic stage and display.
// master: bin_in, load out; busy, ovf, an, seg in. slave: reverse.
interface bcd_display_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             busy;
  logic             ovf;
  logic [3:0]       an;
  logic [7:0]       seg;

  modport master (
    output bin_in, load,
    input  busy, ovf, an, seg
  );

  modport slave (
    input  bin_in, load,
    output busy, ovf, an, seg
  );
endinterface

// File: rtl/bcd_display_b2b.sv
// Sequential double-dabble: BIN_W shift cycles after start.
// Ports: clk, rst, start, bin in; busy, done (last shift), bcd out.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);
  localparam int CW = $clog2(BIN_W);

  logic [BIN_W-1:0] sr;
  logic [15:0]      bcd_r;
  logic [15:0]      adj;
  logic [CW-1:0]    cnt;
  logic             run;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < 4; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      bcd_r <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (run) begin
      {bcd_r, sr} <= {adj[14:0], sr, 1'b0};
      if (cnt == '0)
        run <= 1'b0;
      else
        cnt <= cnt - 1'b1;
    end else if (start) begin
      sr    <= bin;
      bcd_r <= '0;
      cnt   <= CW'(BIN_W - 1);
      run   <= 1'b1;
    end
  end

  // done marks the final shift; bcd is complete the following cycle
  assign done = run && (cnt == '0);
  assign busy = run;
  assign bcd  = bcd_r;

endmodule

// File: rtl/bcd_display.sv
// Captures a binary result, converts to BCD, scans a 4-digit display.
// Ports: clk, rst (async, active-high), bus (bcd_display_if.slave).
module bcd_display
  import calc_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  bcd_display_if.slave  bus
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t           state;
  logic             busy_r;
  logic             pend_vld;
  logic [BIN_W-1:0] pend_val;
  logic [BIN_W-1:0] cap;
  logic [3:0][3:0]  dig;
  logic             ovf_r;

  logic             start;
  logic [BIN_W-1:0] start_val;
  logic             conv_busy;
  logic             conv_done;
  logic [15:0]      bcd;

  logic [DW-1:0]    div;
  logic [1:0]       idx;
  logic [3:0]       an_r;
  logic [7:0]       seg_r;

  logic [3:0][3:0]  dig_n;
  logic             ovf_n;
  logic [1:0]       idx_n;
  logic [3:0]       lz;
  logic [7:0]       seg_n;
  logic             wrap;

  function automatic logic [7:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = SEG_0;
      4'd1:    seg_dec = SEG_1;
      4'd2:    seg_dec = SEG_2;
      4'd3:    seg_dec = SEG_3;
      4'd4:    seg_dec = SEG_4;
      4'd5:    seg_dec = SEG_5;
      4'd6:    seg_dec = SEG_6;
      4'd7:    seg_dec = SEG_7;
      4'd8:    seg_dec = SEG_8;
      4'd9:    seg_dec = SEG_9;
      default: seg_dec = SEG_BLANK;
    endcase
  endfunction

  // A load in COMMIT, or a held pending value, restarts at once;
  // the live load is the newest value so it wins over pending.
  always_comb begin
    start     = 1'b0;
    start_val = bus.bin_in;
    case (state)
      S_IDLE:   start = bus.load && !conv_busy;
      S_COMMIT: begin
        start = (bus.load || pend_vld) && !conv_busy;
        if (!bus.load)
          start_val = pend_val;
      end
      default:  start = 1'b0;
    endcase
  end

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (start_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_r   <= 1'b0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      cap      <= '0;
      dig      <= '0;
      ovf_r    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cap    <= start_val;
            busy_r <= 1'b1;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          if (bus.load) begin
            pend_vld <= 1'b1;
            pend_val <= bus.bin_in;
          end
          if (conv_done)
            state <= S_COMMIT;
        end
        S_COMMIT: begin
          dig   <= bcd;
          ovf_r <= cap > BIN_W'(MAX_DISP);
          if (start) begin
            cap      <= start_val;
            pend_vld <= 1'b0;
            state    <= S_CONV;
          end else begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // seg/an are registered from next-cycle values so a commit
  // shows up in the same cycle as the committed digit regs.
  always_comb begin
    wrap  = (div == DW'(SCAN_DIV - 1));
    idx_n = wrap ? idx + 2'd1 : idx;
    dig_n = dig;
    ovf_n = ovf_r;
    if (state == S_COMMIT) begin
      dig_n = bcd;
      ovf_n = cap > BIN_W'(MAX_DISP);
    end
    lz[3] = (dig_n[3] == 4'd0);
    lz[2] = lz[3] && (dig_n[2] == 4'd0);
    lz[1] = lz[2] && (dig_n[1] == 4'd0);
    lz[0] = 1'b0;
    if (ovf_n)
      seg_n = SEG_DASH;
    else if (lz[idx_n])
      seg_n = SEG_BLANK;
    else
      seg_n = seg_dec(dig_n[idx_n]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      idx   <= '0;
      an_r  <= 4'b1110;
      seg_r <= SEG_0;
    end else begin
      div   <= wrap ? '0 : div + 1'b1;
      idx   <= idx_n;
      an_r  <= ~(4'b0001 << idx_n);
      seg_r <= seg_n;
    end
  end

  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;
  assign bus.an   = an_r;
  assign bus.seg  = seg_r;

endmodule
